// File: rtl/sum_ascii_framer.sv
// sum_ascii_framer: captures the latched operand sum on a rising edge of start,
// splits it into tens/units by repeated subtract-10, and streams the ASCII
// frame "<tens><units>\r\n" to the UART TX byte interface over valid/ready.
// Optional build macro FRAMER_PREFIX_EN prepends "S=" to every frame.
module sum_ascii_framer #(
    parameter int OPERAND_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [OPERAND_W:0] sum_in,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               frame_done
);

    localparam int SUM_W = OPERAND_W + 1;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] CONV       = 3'd1;
    localparam logic [2:0] SEND_TENS  = 3'd2;
    localparam logic [2:0] SEND_UNITS = 3'd3;
    localparam logic [2:0] SEND_CR    = 3'd4;
    localparam logic [2:0] SEND_LF    = 3'd5;
`ifdef FRAMER_PREFIX_EN
    localparam logic [2:0] SEND_S     = 3'd6;
    localparam logic [2:0] SEND_EQ    = 3'd7;
`endif

    logic [2:0]       state;
    logic             start_q;
    logic [SUM_W-1:0] work;
    logic [2:0]       tens;
    logic [7:0]       work_ext;
    logic             start_edge;
    logic             xfer;

    // Map a decimal digit value (0..9) onto its ASCII character.
    function automatic logic [7:0] ascii_digit(input logic [7:0] d);
        return 8'h30 + d;
    endfunction

    assign work_ext   = {{(8 - SUM_W){1'b0}}, work};
    assign start_edge = start & ~start_q;
    assign xfer       = tx_valid & tx_ready;
    assign busy       = (state != IDLE);

    // Frame sequencer: capture, decimal conversion, then one byte per accepted handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            work       <= '0;
            tens       <= 3'd0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            start_q    <= start;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        work  <= sum_in;
                        tens  <= 3'd0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    if (work_ext >= 8'd10) begin
                        work <= work - SUM_W'(10);
                        tens <= tens + 3'd1;
                    end else begin
                        tx_valid <= 1'b1;
`ifdef FRAMER_PREFIX_EN
                        state    <= SEND_S;
                        tx_data  <= 8'h53;
`else
                        state    <= SEND_TENS;
                        tx_data  <= ascii_digit({5'd0, tens});
`endif
                    end
                end
`ifdef FRAMER_PREFIX_EN
                SEND_S: begin
                    if (xfer) begin
                        state   <= SEND_EQ;
                        tx_data <= 8'h3D;
                    end
                end
                SEND_EQ: begin
                    if (xfer) begin
                        state   <= SEND_TENS;
                        tx_data <= ascii_digit({5'd0, tens});
                    end
                end
`endif
                SEND_TENS: begin
                    if (xfer) begin
                        state   <= SEND_UNITS;
                        tx_data <= ascii_digit(work_ext);
                    end
                end
                SEND_UNITS: begin
                    if (xfer) begin
                        state   <= SEND_CR;
                        tx_data <= 8'h0D;
                    end
                end
                SEND_CR: begin
                    if (xfer) begin
                        state   <= SEND_LF;
                        tx_data <= 8'h0A;
                    end
                end
                SEND_LF: begin
                    if (xfer) begin
                        state      <= IDLE;
                        tx_valid   <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_ascii_framer.sv
// Testbench for sum_ascii_framer: scoreboard of expected bytes checked on every
// accepted transfer, a table of sums, and hand-written multi-cycle sequences.
module tb_sum_ascii_framer;

    localparam int OPERAND_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [OPERAND_W:0] sum_in;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic               frame_done;

    int checks   = 0;
    int fails    = 0;
    int fd_count = 0;
    int xfer_cnt = 0;
    logic [7:0] exp_q[$];

`ifdef FRAMER_PREFIX_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 4;
`endif

    typedef struct {
        int sum;
        int tens;
        int units;
    } vec_t;

    sum_ascii_framer #(.OPERAND_W(OPERAND_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sum_in     (sum_in),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (tx_valid && tx_ready && !reset) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_byte: got %0h, expected no transfer", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int t, input int u);
`ifdef FRAMER_PREFIX_EN
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h3D);
`endif
        exp_q.push_back(8'(8'h30 + t));
        exp_q.push_back(8'(8'h30 + u));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic pulse_start(input int s);
        sum_in = (OPERAND_W + 1)'(s);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Bounded wait for one frame_done, then confirm the frame ended cleanly.
    task automatic wait_done(input string name, input int fd0);
        for (int i = 0; i < 200 && fd_count == fd0; i++) @(negedge clk);
        check({name, "_frame_done"}, fd_count - fd0, 1);
        tick();
        tick();
        check({name, "_busy_after"}, busy, 0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_single_done"}, fd_count - fd0, 1);
    endtask

    initial begin
        vec_t tbl[8];
        int   fd0;
        int   x0;
        tbl = '{'{27, 2, 7}, '{0, 0, 0}, '{30, 3, 0}, '{9, 0, 9},
                '{10, 1, 0}, '{19, 1, 9}, '{31, 3, 1}, '{5, 0, 5}};

        reset    = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b1;
        sum_in   = '0;
        repeat (3) tick();
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        reset = 1'b0;
        tick();

        // Table of sums with the UART always ready.
        for (int i = 0; i < 8; i++) begin
            fd0 = fd_count;
            x0  = xfer_cnt;
            push_frame(tbl[i].tens, tbl[i].units);
            pulse_start(tbl[i].sum);
            check("tbl_busy", busy, 1);
            wait_done("tbl", fd0);
            check("tbl_xfers", xfer_cnt - x0, FRAME_LEN);
        end

        // Latency for sum 30: three subtract cycles, tx_valid on the fourth edge after capture.
        fd0 = fd_count;
        push_frame(3, 0);
        sum_in = 5'd30;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("lat_valid_low", tx_valid, 0);
            tick();
        end
        check("lat_valid_high", tx_valid, 1);
        wait_done("lat", fd0);

        // Backpressure on the units byte.
        fd0 = fd_count;
        x0  = xfer_cnt;
        push_frame(2, 7);
        tx_ready = 1'b0;
        pulse_start(27);
        for (int i = 0; i < 50 && !tx_valid; i++) tick();
        check("bp_first_valid", tx_valid, 1);
`ifdef FRAMER_PREFIX_EN
        tx_ready = 1'b1;
        tick();
        tick();
        tx_ready = 1'b0;
`endif
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_data", tx_data, 8'h37);
            check("bp_hold_valid", tx_valid, 1);
        end
        tx_ready = 1'b1;
        wait_done("bp", fd0);
        check("bp_xfers", xfer_cnt - x0, FRAME_LEN);

        // start held high, plus a second rising edge while busy.
        fd0 = fd_count;
        x0  = xfer_cnt;
        push_frame(2, 7);
        sum_in = 5'd27;
        start  = 1'b1;
        repeat (4) tick();
        start  = 1'b0;
        tick();
        check("hold_busy_mid", busy, 1);
        start  = 1'b1;
        repeat (100) tick();
        start  = 1'b0;
        repeat (5) tick();
        check("hold_one_done", fd_count - fd0, 1);
        check("hold_xfers", xfer_cnt - x0, FRAME_LEN);
        check("hold_queue_empty", exp_q.size(), 0);

        // Reset while the CR byte is pending.
`ifdef FRAMER_PREFIX_EN
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h3D);
`endif
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h37);
        tx_ready = 1'b1;
        pulse_start(27);
        for (int i = 0; i < 50 && !(tx_valid && tx_data == 8'h37); i++) @(negedge clk);
        check("rst_units_seen", tx_data, 8'h37);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        check("rst_cr_pending", tx_data, 8'h0D);
        fd0   = fd_count;
        reset = 1'b1;
        tick();
        check("rst_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", tx_data, 8'h00);
        reset    = 1'b0;
        tx_ready = 1'b1;
        repeat (5) tick();
        check("rst_no_done", fd_count - fd0, 0);
        check("rst_queue_empty", exp_q.size(), 0);
        fd0 = fd_count;
        push_frame(0, 9);
        pulse_start(9);
        wait_done("rst_after", fd0);

        // sum_in changes after capture must not affect the frame.
        fd0 = fd_count;
        push_frame(1, 2);
        sum_in = 5'd0;
        tick();
        pulse_start(12);
        sum_in = 5'd15;
        wait_done("late_sum", fd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
